// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//
// Drains the read port of the dual-clock FIFO and turns it into a valid/ready
// stream. Everything here runs in the read clock domain. The stream sustains
// one word per cycle when the FIFO has data and downstream is ready.
//
// The FIFO returns data one cycle after a read request. A 2-entry holding
// buffer absorbs that latency, so read requests can run ahead of downstream
// acceptance by up to two words.
//
// The output stream is framed into bursts of BURST_LEN words. m_last marks the
// final word of each burst. A running count of accepted words is also kept.
//
// Ports:
//   rclk        read-domain clock, rising edge
//   rrst        synchronous active-high reset
//   fifo_empty  FIFO empty flag (rclk domain)
//   fifo_data   FIFO read data, valid the cycle after an accepted read
//   fifo_r_en   FIFO read request
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream data (holding buffer head)
//   m_last      last word of the current burst
//   words_out   words accepted since reset, wraps modulo 2^CNT_WIDTH
//   idle        nothing buffered, nothing in flight, FIFO empty
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  idle
);

  // The burst counter is sized for the widest legal BURST_LEN (65535).
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [1:0]            held;
  logic                  inflight;
  logic [15:0]           burst_cnt;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic                  pop;
  logic [2:0]            occupancy;

  assign pop       = m_valid && m_ready;
  assign occupancy = {1'b0, held} + {2'b00, inflight};

  // A new read is only issued when the buffer is guaranteed to have room for
  // the word when it returns next cycle. That is the case when the occupancy
  // after this cycle's pop is below two. pop can only be 1 when held > 0,
  // so the subtraction never underflows.
  assign fifo_r_en = !rrst && !fifo_empty && ((occupancy - {2'b00, pop}) < 3'd2);

  assign m_valid   = (held != 2'd0);
  assign m_data    = head_data;
  // This depends only on registers that change on a pop, so it holds stable
  // while the stream is stalled.
  assign m_last    = m_valid && (burst_cnt == LAST_IDX);
  assign words_out = word_cnt;
  assign idle      = (held == 2'd0) && !inflight && fifo_empty;

  // The holding buffer is a two-deep shift register with the head at the
  // output. A returning word goes to the first free slot, taking into
  // account a pop happening in the same cycle.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      head_data <= '0;
      tail_data <= '0;
      held      <= 2'd0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      case ({inflight, pop})
        2'b10: begin
          if (held == 2'd0) begin
            head_data <= fifo_data;
          end else begin
            tail_data <= fifo_data;
          end
          held <= held + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          held      <= held - 2'd1;
        end
        2'b11: begin
          if (held == 2'd1) begin
            head_data <= fifo_data;
          end else begin
            head_data <= tail_data;
            tail_data <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The burst position and the delivered-word count advance on every
  // accepted word. The burst position restarts after the word flagged last.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      burst_cnt <= 16'd0;
      word_cnt  <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 1'b1;
      if (m_last) begin
        burst_cnt <= 16'd0;
      end else begin
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end

  // The read-issue rule must make a capture into a full buffer impossible.
  a_no_overflow : assert property (@(posedge rclk) disable iff (rrst)
    !(inflight && !pop && (held == 2'd2)));

  a_held_range : assert property (@(posedge rclk) disable iff (rrst)
    held != 2'd3);

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        m_ready;

  logic        renA, validA, lastA, idleA;
  logic [7:0]  dataA;
  logic [15:0] woA;
  logic        renB, validB, lastB, idleB;
  logic [7:0]  dataB;
  logic [3:0]  woB;

  exp_t        expQ[$];
  logic [7:0]  fifoQ[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          renHist[0:4095];
  bit          validHist[0:4095];
  logic [15:0] expCntA = 16'd0;
  logic [3:0]  expCntB = 4'd0;

  // Main DUT with default framing and counter width.
  fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dutA (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(renA), .m_valid(validA), .m_ready(m_ready), .m_data(dataA),
    .m_last(lastA), .words_out(woA), .idle(idleA)
  );

  // Second DUT sharing the same FIFO: single-word bursts and a 4-bit counter.
  // Its read timing does not depend on these parameters, so it tracks dutA.
  fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)) dutB (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(renB), .m_valid(validB), .m_ready(m_ready), .m_data(dataB),
    .m_last(lastB), .words_out(woB), .idle(idleB)
  );

  always #5 rclk = ~rclk;

  // FIFO read port model: registered read data, empty flag updated shortly
  // after the edge like a real FIFO's registered flag.
  always @(posedge rclk) begin
    if (renA && fifoQ.size() > 0) begin
      fifo_data <= fifoQ.pop_front();
    end
  end

  always @(posedge rclk) begin
    #2;
    fifo_empty = (fifoQ.size() == 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and scoreboard: records per-cycle history and checks every
  // accepted word against the expected queue.
  always @(negedge rclk) begin
    exp_t e;
    cyc++;
    if (cyc < 4096) begin
      renHist[cyc]   = renA;
      validHist[cyc] = validA;
    end
    if (rrst) begin
      expCntA = 16'd0;
      expCntB = 4'd0;
    end else begin
      if (renA) checkOutput("ren_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (renA || renB) checkOutput("ren_b_tracks_a", {31'd0, renB}, {31'd0, renA});
      if (validA || validB) checkOutput("valid_b_tracks_a", {31'd0, validB}, {31'd0, validA});
      if (validA && m_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected none", dataA);
        end else begin
          e = expQ.pop_front();
          checkOutput("data_a", {24'd0, dataA}, {24'd0, e.data});
          checkOutput("last_a", {31'd0, lastA}, {31'd0, e.last});
          checkOutput("data_b", {24'd0, dataB}, {24'd0, e.data});
          checkOutput("last_b", {31'd0, lastB}, 32'd1);
          checkOutput("words_out_a", {16'd0, woA}, {16'd0, expCntA});
          checkOutput("words_out_b", {28'd0, woB}, {28'd0, expCntB});
          expCntA = expCntA + 16'd1;
          expCntB = expCntB + 4'd1;
        end
      end
    end
  end

  // Loads n words (first, first+step, ...) into the FIFO and the expected
  // queue; bit i of lastMask gives the hand-computed m_last of word i.
  task automatic applyStimulus(input logic [7:0] first, input logic [7:0] step,
                               input int n, input logic [15:0] lastMask);
    exp_t e;
    logic [7:0] w;
    w = first;
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(w);
      e.data = w;
      e.last = lastMask[i];
      expQ.push_back(e);
      w = w + step;
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge rclk);
      if (expQ.size() == 0 && idleA) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got %0d words pending, expected 0 within %0d cycles",
               name, expQ.size(), budget);
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic scanHistory(input int base, output int cnt, output int first,
                             output int last, output int firstValid);
    cnt = 0;
    first = -1;
    last = -1;
    firstValid = -1;
    for (int i = base + 1; i <= cyc && i < 4096; i++) begin
      if (renHist[i]) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (validHist[i] && firstValid < 0) firstValid = i;
    end
  endtask

  initial begin
    int base, cnt, first, last, firstValid;

    rrst = 1'b1;
    m_ready = 1'b0;
    stepCycles(3);
    rrst = 1'b0;

    @(negedge rclk);
    $display("[TB] reset state");
    checkOutput("reset_valid", {31'd0, validA}, 32'd0);
    checkOutput("reset_data", {24'd0, dataA}, 32'd0);
    checkOutput("reset_last", {31'd0, lastA}, 32'd0);
    checkOutput("reset_words_out", {16'd0, woA}, 32'd0);
    checkOutput("reset_idle", {31'd0, idleA}, 32'd1);
    checkOutput("reset_ren", {31'd0, renA}, 32'd0);
    @(posedge rclk);
    #1;

    $display("[TB] full-rate burst");
    m_ready = 1'b1;
    base = cyc;
    applyStimulus(8'h11, 8'h11, 4, 16'b1000);
    waitDrain("drain_t1", 40);
    scanHistory(base, cnt, first, last, firstValid);
    checkOutput("t1_ren_count", cnt, 32'd4);
    checkOutput("t1_ren_consecutive", last - first, 32'd3);
    checkOutput("t1_latency", firstValid - first, 32'd2);
    @(negedge rclk);
    checkOutput("t1_words_out", {16'd0, woA}, 32'd4);
    checkOutput("t1_idle", {31'd0, idleA}, 32'd1);
    @(posedge rclk);
    #1;

    $display("[TB] backpressure");
    m_ready = 1'b0;
    base = cyc;
    applyStimulus(8'hA1, 8'h01, 4, 16'b1000);
    stepCycles(6);
    @(negedge rclk);
    scanHistory(base, cnt, first, last, firstValid);
    checkOutput("t2_ren_count", cnt, 32'd2);
    checkOutput("t2_valid", {31'd0, validA}, 32'd1);
    checkOutput("t2_head", {24'd0, dataA}, 32'hA1);
    stepCycles(2);
    @(negedge rclk);
    checkOutput("t2_head_stable", {24'd0, dataA}, 32'hA1);
    checkOutput("t2_last_stable", {31'd0, lastA}, 32'd0);
    @(posedge rclk);
    #1;
    m_ready = 1'b1;
    waitDrain("drain_t2", 40);
    checkOutput("t2_words_out", {16'd0, woA}, 32'd8);

    $display("[TB] toggling ready");
    applyStimulus(8'h31, 8'h01, 8, 16'b1000_1000);
    for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
      m_ready = (i % 2 == 0);
      stepCycles(1);
    end
    m_ready = 1'b1;
    waitDrain("drain_t3", 40);
    checkOutput("t3_words_out", {16'd0, woA}, 32'd16);

    $display("[TB] reset mid-stream");
    m_ready = 1'b0;
    applyStimulus(8'h51, 8'h01, 3, 16'b0000);
    stepCycles(2);
    rrst = 1'b1;
    fifoQ.delete();
    expQ.delete();
    @(negedge rclk);
    checkOutput("t4_pre_reset_valid", {31'd0, validA}, 32'd1);
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    @(negedge rclk);
    checkOutput("t4_valid", {31'd0, validA}, 32'd0);
    checkOutput("t4_words_out_a", {16'd0, woA}, 32'd0);
    checkOutput("t4_words_out_b", {28'd0, woB}, 32'd0);
    checkOutput("t4_last", {31'd0, lastA}, 32'd0);
    @(posedge rclk);
    #1;
    m_ready = 1'b1;
    applyStimulus(8'h61, 8'h01, 4, 16'b1000);
    waitDrain("drain_t4", 40);

    $display("[TB] counter wrap");
    applyStimulus(8'h70, 8'h01, 13, 16'b0000_1000_1000_1000);
    waitDrain("drain_t5", 60);
    @(negedge rclk);
    checkOutput("t5_words_out_a", {16'd0, woA}, 32'd17);
    checkOutput("t5_words_out_b", {28'd0, woB}, 32'd1);
    checkOutput("t5_idle_b", {31'd0, idleB}, 32'd1);
    checkOutput("t5_valid", {31'd0, validA}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drainer for the team's dual-clock FIFO. Lives entirely in the read clock domain.
- Pulls words from the FIFO read port (r_en / empty / data_out) and presents them as a valid/ready stream, one word per cycle at full throughput.
- Hides the FIFO's one-cycle registered read latency with a 2-entry holding buffer.
- Frames the output stream into bursts of BURST_LEN words with a last flag, and keeps a running delivered-word count.

Parameters:
- DATA_WIDTH, 8: width of FIFO data and stream data.
- BURST_LEN, 4: words per burst; m_last asserts on the final word of each burst. Legal range is 1..65535.
- CNT_WIDTH, 16: width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock; all logic is on its rising edge.
- rrst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, already in the rclk domain.
- fifo_data  input  DATA_WIDTH  FIFO data_out; valid on the cycle after a cycle in which fifo_r_en=1 and fifo_empty=0.
- fifo_r_en  output  1  FIFO read request.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  final word of the current burst.
- words_out  output  CNT_WIDTH  words accepted downstream since reset; wraps modulo 2^CNT_WIDTH.
- idle  output  1  high when nothing is buffered, nothing is in flight, and fifo_empty=1.

Behaviour:
- Reset (rrst=1 at a clock edge):
  - holding buffer cleared, in-flight flag cleared, burst counter = 0, words_out = 0.
  - m_valid=0, m_data=0, m_last=0.
  - fifo_r_en is forced to 0 while rrst=1.
  - Reset mid-burst discards buffered and in-flight words; a FIFO word returned during the reset cycle is dropped.
- Read issue (combinational): fifo_r_en = !rrst && !fifo_empty && (held + inflight - pop) < 2.
  - held = words in the holding buffer (0..2).
  - inflight = 1 if fifo_r_en was issued last cycle with fifo_empty=0.
  - pop = m_valid && m_ready.
- Capture: when inflight=1, fifo_data is written into the buffer tail at the clock edge. Capture and pop in the same cycle are legal; held stays unchanged.
- Overflow: the buffer never overflows, by construction of fifo_r_en. A capture into a full buffer is an RTL bug and should be covered by an assertion.
- Stream rules:
  - m_valid = (held > 0).
  - m_data and m_last come from the buffer head.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never drops without a handshake, except on reset.
- Latency: first word at an idle block appears on m_valid 2 cycles after fifo_empty falls (cycle 0 r_en, cycle 1 capture, cycle 2 valid). It is registered; no combinational path from fifo_empty to m_valid.
- Throughput: with m_ready held high and FIFO non-empty, one word per cycle sustained.
- Backpressure: with m_ready=0, at most 2 words are read and then fifo_r_en stays 0 until a pop.
- Burst framing:
  - burst counter increments on each pop.
  - m_last = 1 on the head word when the counter equals BURST_LEN-1; m_last is computed for the head word and held stable while stalled.
  - on a pop with m_last=1 the counter returns to 0.
  - BURST_LEN=1 means every word has m_last=1.
- words_out increments on every pop and wraps from 2^CNT_WIDTH-1 to 0.
- Empty boundary: if fifo_empty rises while words are buffered, the buffered words still drain normally and m_valid deasserts after the last pop.
- idle = (held==0) && !inflight && fifo_empty.

Test Plan:
- Reset then FIFO loaded with 0x11,0x22,0x33,0x44 and m_ready=1 -> fifo_r_en high for 4 consecutive cycles; m_data 0x11..0x44 on 4 consecutive cycles starting 2 cycles after the first r_en; m_last=1 only on 0x44; words_out=4; idle=1 afterwards.
- Same 4 words with m_ready=0 -> exactly 2 r_en pulses, m_valid=1 with m_data=0x11 stable. Then m_ready=1 -> all 4 words delivered in order with no duplicates or drops.
- m_ready toggling 1,0,1,0 over 8 words, BURST_LEN=4 -> m_last on words 4 and 8 only; order preserved; fifo_r_en never asserted while fifo_empty=1.
- rrst pulsed for 1 cycle with 2 words buffered and 1 in flight -> next cycle m_valid=0, words_out=0, burst counter=0; the next delivered word carries a fresh burst count (m_last on the 4th word after reset).
- BURST_LEN=1 with 3 words -> m_last=1 on every word.
- CNT_WIDTH=4 with 17 words -> words_out wraps to 1.
